// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter/sequencer for a single-port synchronous memory
//
// Purpose: serialises accesses from two masters onto one synchronous-read memory.
// Port 0 is the core fetch/load/store path; port 1 is a secondary master
// (loader, debug or DMA). Each transaction is IDLE -> ISSUE -> [WAIT] -> ACK.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   mN_req/we/addr/       request from master N, held stable until mN_ack
//   wdata/wmask
//   mN_ack                one-cycle completion pulse
//   mN_rdata              read data, held until master N's next read completes
//   mem_en/we/addr/       registered memory strobe and access fields
//   wdata/wmask
//   mem_rdata             memory read data, valid RD_LAT cycles after mem_en
//   busy, grant           transaction in flight / owning port

module mem_arbiter #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

  state_e                state_q;
  logic                  last_grant_q;
  logic                  grant_q;
  logic                  busy_q;
  logic [2:0]            cnt_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic [DATA_W/8-1:0]   mem_wmask_q;
  logic                  m0_ack_q;
  logic                  m1_ack_q;
  logic [DATA_W-1:0]     m0_rdata_q;
  logic [DATA_W-1:0]     m1_rdata_q;

  // Winner selection: a lone requester wins; on a tie the port that did not
  // win last time goes, which gives strict alternation under contention.
  logic                  any_req_d;
  logic                  win_d;
  logic                  sel_we_d;
  logic [ADDR_W-1:0]     sel_addr_d;
  logic [DATA_W-1:0]     sel_wdata_d;
  logic [DATA_W/8-1:0]   sel_wmask_d;

  always_comb begin
    any_req_d   = m0_req | m1_req;
    win_d       = (m0_req & m1_req) ? ~last_grant_q : m1_req;
    sel_we_d    = win_d ? m1_we    : m0_we;
    sel_addr_d  = win_d ? m1_addr  : m0_addr;
    sel_wdata_d = win_d ? m1_wdata : m0_wdata;
    sel_wmask_d = win_d ? m1_wmask : m0_wmask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= 3'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      mem_en_q <= 1'b0;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            grant_q      <= win_d;
            last_grant_q <= win_d;
            mem_we_q     <= sel_we_d;
            mem_addr_q   <= sel_addr_d;
            mem_wdata_q  <= sel_wdata_d;
            mem_wmask_q  <= sel_wmask_d;
            mem_en_q     <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_we_q) begin
            m0_ack_q <= ~grant_q;
            m1_ack_q <= grant_q;
            state_q  <= ACK;
          end else begin
            cnt_q   <= 3'(RD_LAT);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          // Count of 1 marks the cycle mem_rdata is valid.
          if (cnt_q == 3'd1) begin
            if (grant_q) begin
              m1_rdata_q <= mem_rdata;
              m1_ack_q   <= 1'b1;
            end else begin
              m0_rdata_q <= mem_rdata;
              m0_ack_q   <= 1'b1;
            end
            state_q <= ACK;
          end
        end
        ACK: begin
          // Requests are not sampled here; a held req restarts from IDLE.
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign busy      = busy_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (RD_LAT=1 and RD_LAT=3 instances)

module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Index [k][p]: instance k (0: RD_LAT=1, 1: RD_LAT=3), port p.
  logic        req_s   [2][2];
  logic        we_s    [2][2];
  logic [31:0] addr_s  [2][2];
  logic [31:0] wdata_s [2][2];
  logic [3:0]  wmask_s [2][2];
  logic        ack_s   [2][2];
  logic [31:0] rdata_s [2][2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wmask [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];
  logic        grant     [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.RD_LAT(g == 0 ? 1 : 3), .ADDR_W(32), .DATA_W(32)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .m0_req    (req_s[g][0]),
      .m0_we     (we_s[g][0]),
      .m0_addr   (addr_s[g][0]),
      .m0_wdata  (wdata_s[g][0]),
      .m0_wmask  (wmask_s[g][0]),
      .m0_ack    (ack_s[g][0]),
      .m0_rdata  (rdata_s[g][0]),
      .m1_req    (req_s[g][1]),
      .m1_we     (we_s[g][1]),
      .m1_addr   (addr_s[g][1]),
      .m1_wdata  (wdata_s[g][1]),
      .m1_wmask  (wmask_s[g][1]),
      .m1_ack    (ack_s[g][1]),
      .m1_rdata  (rdata_s[g][1]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_wmask (mem_wmask[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g]),
      .grant     (grant[g])
    );
  end

  // Read-only memory model; data appears exactly RD_LAT cycles after mem_en,
  // otherwise a poison value so an early or late capture is visible.
  logic [31:0] mem  [16];
  logic [31:0] pipe [2][3];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pipe[k][0] <= (mem_en[k] && !mem_we[k]) ? mem[mem_addr[k][5:2]] : 32'hBAD0BAD0;
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  typedef struct {
    int          inst;
    int          port;
    logic [31:0] data;
    int          cyc;
  } ack_e;

  typedef struct {
    int          inst;
    int          port;
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } iss_e;

  ack_e ack_q[$];
  iss_e iss_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  // Monitor: pops the first expectation for the instance whenever it shows
  // an ack or a memory strobe.
  always @(negedge clk) begin : mon
    int idx;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        if (ack_s[k][0] || ack_s[k][1]) begin
          idx = -1;
          for (int i = 0; i < ack_q.size(); i++)
            if (idx < 0 && ack_q[i].inst == k) idx = i;
          if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack inst%0d cycle %0d: got ack expected none", k, cyc);
          end else begin
            chk("ack_both", k, 32'(ack_s[k][0] & ack_s[k][1]), 32'd0);
            chk("ack_port", k, {31'b0, ack_s[k][1]}, ack_q[idx].port);
            chk("ack_cycle", k, cyc, ack_q[idx].cyc);
            chk("ack_rdata", k, rdata_s[k][ack_q[idx].port], ack_q[idx].data);
            ack_q.delete(idx);
          end
        end
        if (mem_en[k]) begin
          idx = -1;
          for (int i = 0; i < iss_q.size(); i++)
            if (idx < 0 && iss_q[i].inst == k) idx = i;
          if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_mem_en inst%0d cycle %0d: got mem_en expected none", k, cyc);
          end else begin
            chk("iss_cycle", k, cyc, iss_q[idx].cyc);
            chk("iss_grant", k, {31'b0, grant[k]}, iss_q[idx].port);
            chk("iss_busy", k, {31'b0, busy[k]}, 32'd1);
            chk("iss_we", k, {31'b0, mem_we[k]}, {31'b0, iss_q[idx].we});
            chk("iss_addr", k, mem_addr[k], iss_q[idx].addr);
            chk("iss_wdata", k, mem_wdata[k], iss_q[idx].wdata);
            chk("iss_wmask", k, {28'b0, mem_wmask[k]}, {28'b0, iss_q[idx].wmask});
            iss_q.delete(idx);
          end
        end
      end
    end
  end

  task automatic set_req(int k, int p, logic r, logic we, logic [31:0] a,
                         logic [31:0] wd, logic [3:0] wm);
    req_s[k][p]   = r;
    we_s[k][p]    = we;
    addr_s[k][p]  = a;
    wdata_s[k][p] = wd;
    wmask_s[k][p] = wm;
  endtask

  // Issue in cycle ci; ack one cycle later for writes, 1+RD_LAT later for reads.
  task automatic exp_txn(int k, int p, int ci, logic we, logic [31:0] a, logic [31:0] wd,
                         logic [3:0] wm, logic [31:0] d, bit with_ack);
    int lat;
    lat = (k == 0) ? 1 : 3;
    iss_q.push_back('{k, p, ci, we, a, wd, wm});
    if (with_ack) ack_q.push_back('{k, p, d, ci + 1 + (we ? 0 : lat)});
  endtask

  task automatic wait_ack(int k, int p, int n);
    int got;
    got = 0;
    for (int i = 0; i < 60 && got < n; i++) begin
      @(negedge clk);
      if (ack_s[k][p]) got++;
    end
    if (got < n) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout inst%0d port%0d: got %0d acks expected %0d", k, p, got, n);
    end
  endtask

  task automatic check_rst(int k);
    chk("rst_mem_en", k, {31'b0, mem_en[k]}, 32'd0);
    chk("rst_mem_we", k, {31'b0, mem_we[k]}, 32'd0);
    chk("rst_mem_addr", k, mem_addr[k], 32'd0);
    chk("rst_mem_wdata", k, mem_wdata[k], 32'd0);
    chk("rst_mem_wmask", k, {28'b0, mem_wmask[k]}, 32'd0);
    chk("rst_m0_ack", k, {31'b0, ack_s[k][0]}, 32'd0);
    chk("rst_m1_ack", k, {31'b0, ack_s[k][1]}, 32'd0);
    chk("rst_m0_rdata", k, rdata_s[k][0], 32'd0);
    chk("rst_m1_rdata", k, rdata_s[k][1], 32'd0);
    chk("rst_busy", k, {31'b0, busy[k]}, 32'd0);
    chk("rst_grant", k, {31'b0, grant[k]}, 32'd0);
  endtask

  initial begin
    int c;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) set_req(k, p, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
    mem[4]  = 32'hDEADBEEF;
    mem[5]  = 32'hCAFEF00D;
    mem[12] = 32'h0A0A0A0A;
    mem[13] = 32'h1B1B1B1B;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_rst(0);
    check_rst(1);
    reset = 1'b0;

    // Port 0 read on both instances: RD_LAT=1 @0x10 and RD_LAT=3 @0x14.
    @(posedge clk); #1;
    c = cyc;
    set_req(0, 0, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
    set_req(1, 0, 1'b1, 1'b0, 32'h14, 32'd0, 4'd0);
    exp_txn(0, 0, c + 1, 1'b0, 32'h10, 32'd0, 4'd0, 32'hDEADBEEF, 1'b1);
    exp_txn(1, 0, c + 1, 1'b0, 32'h14, 32'd0, 4'd0, 32'hCAFEF00D, 1'b1);
    wait_ack(0, 0, 1);
    set_req(0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    wait_ack(1, 0, 1);
    set_req(1, 0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

    // Port 1 write: m1_rdata stays at its reset value.
    @(posedge clk); #1;
    c = cyc;
    set_req(0, 1, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'b0011);
    exp_txn(0, 1, c + 1, 1'b1, 32'h20, 32'h12345678, 4'b0011, 32'd0, 1'b1);
    wait_ack(0, 1, 1);
    set_req(0, 1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

    // Port 0 holds req through its ack: two transactions, one mem_en each.
    @(posedge clk); #1;
    c = cyc;
    set_req(0, 0, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
    exp_txn(0, 0, c + 1, 1'b0, 32'h10, 32'd0, 4'd0, 32'hDEADBEEF, 1'b1);
    exp_txn(0, 0, c + 5, 1'b0, 32'h10, 32'd0, 4'd0, 32'hDEADBEEF, 1'b1);
    wait_ack(0, 0, 2);
    set_req(0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

    // Reset in the WAIT state: outputs clear at once, no ack follows.
    @(posedge clk); #1;
    c = cyc;
    set_req(0, 0, 1'b1, 1'b0, 32'h34, 32'd0, 4'd0);
    exp_txn(0, 0, c + 1, 1'b0, 32'h34, 32'd0, 4'd0, 32'd0, 1'b0);
    @(posedge clk);
    @(posedge clk); #2;
    chk("busy_in_wait", 0, {31'b0, busy[0]}, 32'd1);
    reset = 1'b1;
    #1;
    check_rst(0);
    set_req(0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Both ports read continuously: grants 0,1,0,1, acks every 4 cycles.
    @(posedge clk); #1;
    c = cyc;
    set_req(0, 0, 1'b1, 1'b0, 32'h30, 32'd0, 4'd0);
    set_req(0, 1, 1'b1, 1'b0, 32'h34, 32'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        exp_txn(0, 0, c + 1 + 4 * i, 1'b0, 32'h30, 32'd0, 4'd0, 32'h0A0A0A0A, 1'b1);
      else
        exp_txn(0, 1, c + 1 + 4 * i, 1'b0, 32'h34, 32'd0, 4'd0, 32'h1B1B1B1B, 1'b1);
    end
    wait_ack(0, 1, 2);
    set_req(0, 0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(0, 1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("ack_q_left", 0, ack_q.size(), 32'd0);
    chk("iss_q_left", 0, iss_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
